// File: rtl/switch_debouncer_pkg.sv
// Package: switch_pkg
// Shared constants, the switch vector type and the prescaler divisor helper
// for the switch debouncer.
//   NUM_SW_DEFAULT : number of board toggle switches
//   switch_vec_t   : one bit per switch
//   calc_div()     : clock cycles per debounce sample
package switch_pkg;

  localparam int NUM_SW_DEFAULT = 18;

  typedef logic [NUM_SW_DEFAULT-1:0] switch_vec_t;

  // Number of clock cycles between two debounce sample instants.
  function automatic int calc_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage

// File: rtl/switch_debouncer_checker.sv
// Module: switch_debouncer_checker
// Elaboration-time parameter legality checks for the switch debouncer.
// No ports; instantiated by the top with its derived parameters.
//   DIV            : clock cycles per sample, must be at least 2
//   STABLE_SAMPLES : samples needed to accept a level, must be at least 1
module switch_debouncer_checker #(
  parameter int DIV            = 2,
  parameter int STABLE_SAMPLES = 1
) ();

  if (DIV < 2) begin : g_div_too_small
    $error("switch_debouncer: CLK_FREQ_HZ/SAMPLE_HZ must be >= 2");
  end

  if (STABLE_SAMPLES < 1) begin : g_stable_too_small
    $error("switch_debouncer: STABLE_SAMPLES must be >= 1");
  end

endmodule

// File: rtl/switch_debouncer_debounce_cell.sv
// Module: debounce_cell
// One switch bit: 2-flop synchroniser, stability counter, debounced level
// flop and one-cycle rise/fall strobes.
//   clk   : system clock, rising edge
//   rst   : synchronous reset, active high
//   raw   : raw asynchronous switch level
//   tick  : one-cycle sample enable from the shared prescaler
//   db    : debounced level
//   rise  : one-cycle pulse in the first cycle db reads 1 after a 0
//   fall  : one-cycle pulse in the first cycle db reads 0 after a 1
module debounce_cell #(
  parameter int STABLE_SAMPLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic db,
  output logic rise,
  output logic fall
);

  // A single-sample filter still needs a 1-bit counter to keep widths legal.
  localparam int CNT_W = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             db_r;
  logic             rise_r;
  logic             fall_r;
  logic             at_limit_s;

  // Last differing sample before the new level is accepted.
  always_comb begin
    at_limit_s = 1'b0;
    if (cnt_r == CNT_W'(STABLE_SAMPLES - 1)) begin
      at_limit_s = 1'b1;
    end else begin
      at_limit_s = 1'b0;
    end
  end

  // Synchroniser, stability counter, debounced level and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      db_r    <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      // Strobes default low so they last exactly one cycle.
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      if (tick) begin
        if (sync2_r == db_r) begin
          // Returning to the accepted level discards any partial count.
          cnt_r <= {CNT_W{1'b0}};
        end else if (at_limit_s) begin
          db_r   <= sync2_r;
          rise_r <= sync2_r;
          fall_r <= ~sync2_r;
          cnt_r  <= {CNT_W{1'b0}};
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign db   = db_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/switch_debouncer.sv
// Module: switch_debouncer
// Debounces the board toggle switches feeding the priority encoder and
// seven-segment display stage, and emits per-bit edge strobes.
//   CLOCK_50_I    : system clock, rising edge
//   RESET_I       : synchronous reset, active high
//   SWITCH_I      : raw asynchronous switch levels
//   SWITCH_DB_O   : debounced switch levels
//   SWITCH_RISE_O : one-cycle pulse per bit on a debounced 0->1
//   SWITCH_FALL_O : one-cycle pulse per bit on a debounced 1->0
//   CHANGE_O      : one-cycle pulse when any rise/fall bit is set
//   SAMPLE_TICK_O : one-cycle pulse at each sample instant
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int NUM_SW         = NUM_SW_DEFAULT,
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int STABLE_SAMPLES = 8
) (
  input  logic              CLOCK_50_I,
  input  logic              RESET_I,
  input  logic [NUM_SW-1:0] SWITCH_I,
  output logic [NUM_SW-1:0] SWITCH_DB_O,
  output logic [NUM_SW-1:0] SWITCH_RISE_O,
  output logic [NUM_SW-1:0] SWITCH_FALL_O,
  output logic              CHANGE_O,
  output logic              SAMPLE_TICK_O
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, SAMPLE_HZ);
  localparam int PRE_W = $clog2(DIV);

  logic [PRE_W-1:0]  pre_cnt_r;
  logic              tick_r;
  logic              pre_wrap_s;
  logic [NUM_SW-1:0] db_s;
  logic [NUM_SW-1:0] rise_s;
  logic [NUM_SW-1:0] fall_s;

  switch_debouncer_checker #(
    .DIV            (DIV),
    .STABLE_SAMPLES (STABLE_SAMPLES)
  ) u_checker ();

  // Prescaler terminal count.
  always_comb begin
    pre_wrap_s = 1'b0;
    if (pre_cnt_r == PRE_W'(DIV - 1)) begin
      pre_wrap_s = 1'b1;
    end else begin
      pre_wrap_s = 1'b0;
    end
  end

  // Shared sample prescaler; the tick is the cycle after the terminal count,
  // so the first one lands DIV cycles after reset release.
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      pre_cnt_r <= {PRE_W{1'b0}};
      tick_r    <= 1'b0;
    end else begin
      tick_r <= pre_wrap_s;
      if (pre_wrap_s) begin
        pre_cnt_r <= {PRE_W{1'b0}};
      end else begin
        pre_cnt_r <= pre_cnt_r + PRE_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
    debounce_cell #(
      .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_cell (
      .clk  (CLOCK_50_I),
      .rst  (RESET_I),
      .raw  (SWITCH_I[i]),
      .tick (tick_r),
      .db   (db_s[i]),
      .rise (rise_s[i]),
      .fall (fall_s[i])
    );
  end

  assign SWITCH_DB_O   = db_s;
  assign SWITCH_RISE_O = rise_s;
  assign SWITCH_FALL_O = fall_s;
  assign SAMPLE_TICK_O = tick_r;
  // Reduction of the strobe flops: same cycle as the strobes, and no path
  // back to the raw inputs.
  assign CHANGE_O      = |(rise_s | fall_s);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer with DIV=10 and
// STABLE_SAMPLES=4. Expected values are hand-derived from the clock timing.
module tb_switch_debouncer;
  import switch_pkg::*;

  bit          clk = 1'b0;
  logic        rst;
  switch_vec_t sw;
  switch_vec_t db;
  switch_vec_t rise;
  switch_vec_t fall;
  logic        change;
  logic        tick;

  int n_vec = 0;
  int n_err = 0;
  int chg_seen = 0;
  int rise_seen = 0;
  int fall_seen = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .NUM_SW         (18),
    .CLK_FREQ_HZ    (100),
    .SAMPLE_HZ      (10),
    .STABLE_SAMPLES (4)
  ) dut (
    .CLOCK_50_I    (clk),
    .RESET_I       (rst),
    .SWITCH_I      (sw),
    .SWITCH_DB_O   (db),
    .SWITCH_RISE_O (rise),
    .SWITCH_FALL_O (fall),
    .CHANGE_O      (change),
    .SAMPLE_TICK_O (tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock, then sample 1 ns after the edge and tally strobe activity.
  task automatic step();
    @(posedge clk);
    #1;
    if (change === 1'b1) chg_seen++;
    if (|rise) rise_seen++;
    if (|fall) fall_seen++;
  endtask

  // Step until db[idx]==val or max_cyc cycles elapse; lat = cycles stepped.
  task automatic wait_db(input int idx, input logic val, input int max_cyc,
                         output int lat, output int nticks);
    lat = 0;
    nticks = 0;
    while (lat < max_cyc && db[idx] !== val) begin
      step();
      lat++;
      if (tick === 1'b1) nticks++;
    end
  endtask

  initial begin
    int lat;
    int nt;
    int g;

    // Reset for 3 cycles
    rst = 1'b1;
    sw  = '0;
    repeat (3) step();
    chk("rst_db", db, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_chg", change, 0);
    chk("rst_tick", tick, 0);

    // Idle: tick every 10 cycles, first at cycle 10
    rst = 1'b0;
    chg_seen = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      chk("idle_tick", tick, (k % 10 == 0) ? 1 : 0);
    end
    chk("idle_db", db, 0);
    chk("idle_chg_cnt", chg_seen, 0);

    // Bit 9 held high: eval edges 211,221,231,241 -> db after 41 cycles
    sw = 18'h00200;
    wait_db(9, 1'b1, 60, lat, nt);
    chk("b9_lat", lat, 41);
    chk("b9_db", db, 18'h00200);
    chk("b9_rise", rise, 18'h00200);
    chk("b9_fall", fall, 0);
    chk("b9_chg", change, 1);
    step();
    chk("b9_rise_off", rise, 0);
    chk("b9_chg_off", change, 0);

    // Bit 3 glitch of 25 cycles is rejected
    chg_seen = 0;
    sw = 18'h00208;
    repeat (25) step();
    sw = 18'h00200;
    repeat (60) step();
    chk("glitch_db", db, 18'h00200);
    chk("glitch_chg_cnt", chg_seen, 0);

    // Bits 0 and 17 rise together, then fall together
    chg_seen = 0;
    sw = 18'h20201;
    wait_db(0, 1'b1, 60, lat, nt);
    chk("pair_lat_ok", (lat >= 33 && lat <= 43) ? 1 : 0, 1);
    chk("pair_db", db, 18'h20201);
    chk("pair_rise", rise, 18'h20001);
    chk("pair_fall", fall, 0);
    chk("pair_chg", change, 1);
    step();
    chk("pair_rise_off", rise, 0);
    chk("pair_chg_cnt", chg_seen, 1);
    sw = 18'h00200;
    wait_db(0, 1'b0, 60, lat, nt);
    chk("pairf_db", db, 18'h00200);
    chk("pairf_fall", fall, 18'h20001);
    chk("pairf_rise", rise, 0);
    chk("pairf_chg", change, 1);
    step();
    chk("pairf_fall_off", fall, 0);

    // Bit 5 held, reset one cycle after the 3rd tick
    sw = 18'h00220;
    nt = 0;
    g = 0;
    while (nt < 3 && g < 60) begin
      step();
      g++;
      if (tick === 1'b1) nt++;
    end
    chk("rq_ticks3", nt, 3);
    step();
    chk("rq_pre_db", db, 18'h00200);
    rst = 1'b1;
    repeat (3) step();
    chk("rq_rst_db", db, 0);
    chk("rq_rst_chg", change, 0);
    chk("rq_rst_tick", tick, 0);
    rst = 1'b0;
    step();
    chk("rq_first_rise", rise, 0);
    chk("rq_first_fall", fall, 0);
    chk("rq_first_chg", change, 0);
    chk("rq_first_tick", tick, 0);
    wait_db(5, 1'b1, 60, lat, nt);
    chk("rq_lat", lat + 1, 41);
    chk("rq_ticks", nt, 4);
    chk("rq_db", db, 18'h00220);
    chk("rq_rise", rise, 18'h00220);
    chk("rq_chg", change, 1);
    step();

    // Bit 12 bounces every 7 cycles, then held high
    rise_seen = 0;
    fall_seen = 0;
    for (int s = 0; s < 14; s++) begin
      sw[12] = (s % 2 == 0) ? 1'b1 : 1'b0;
      repeat (7) step();
    end
    chk("bnc_db_hold", db, 18'h00220);
    sw[12] = 1'b1;
    wait_db(12, 1'b1, 60, lat, nt);
    chk("bnc_lat_ok", (lat >= 33 && lat <= 43) ? 1 : 0, 1);
    chk("bnc_rise", rise, 18'h01000);
    repeat (30) step();
    chk("bnc_db", db, 18'h01220);
    chk("bnc_rise_cnt", rise_seen, 1);
    chk("bnc_fall_cnt", fall_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
